// File: rtl/dffs_fifo_pkg.sv
// Shared helpers for the dffs_fifo slice.
// Latency: n/a (compile-time helpers only).
// Backpressure: n/a.
package dffs_fifo_pkg;

    // Clamp helper used to keep derived widths legal for degenerate parameters.
    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/dffs_fifo_ptr.sv
// Pointer, occupancy and flag tracking for dffs_fifo.
// Latency: flags and COUNT are registered from next-state pointers (update on the push/pop edge).
// Backpressure: none here; push/pop are already qualified by the top level.
module dffs_fifo_ptr
    import dffs_fifo_pkg::*;
#(
    parameter int SIZE = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            FLUSH,
    input  logic            push,
    input  logic            pop,
    output logic [SIZE-1:0] waddr,
    output logic [SIZE-1:0] raddr,
    output logic [SIZE:0]   COUNT,
    output logic            FULL,
    output logic            EMPTY
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int PW = max_i(SIZE, 1) + 1;

    logic [PW-1:0] wptr, rptr;
    logic [PW-1:0] wptr_nxt, rptr_nxt;
    logic [SIZE:0] count_nxt;
    logic          full_nxt, empty_nxt;

    // Next-state pointers and count; flush wins over any concurrent push/pop.
    always_comb begin
        wptr_nxt  = wptr;
        rptr_nxt  = rptr;
        count_nxt = COUNT;
        if (FLUSH) begin
            wptr_nxt  = '0;
            rptr_nxt  = '0;
            count_nxt = '0;
        end else begin
            if (push) wptr_nxt = wptr + PW'(1);
            if (pop)  rptr_nxt = rptr + PW'(1);
            case ({push, pop})
                2'b10:   count_nxt = COUNT + (SIZE+1)'(1);
                2'b01:   count_nxt = COUNT - (SIZE+1)'(1);
                default: count_nxt = COUNT;
            endcase
        end
        empty_nxt = (wptr_nxt == rptr_nxt);
        full_nxt  = (wptr_nxt[PW-2:0] == rptr_nxt[PW-2:0]) &&
                    (wptr_nxt[PW-1] != rptr_nxt[PW-1]);
    end

    // State register; reset drops every queued word immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr  <= '0;
            rptr  <= '0;
            COUNT <= '0;
            FULL  <= 1'b0;
            EMPTY <= 1'b1;
        end else begin
            wptr  <= wptr_nxt;
            rptr  <= rptr_nxt;
            COUNT <= count_nxt;
            FULL  <= full_nxt;
            EMPTY <= empty_nxt;
        end
    end

    assign waddr = wptr[SIZE-1:0];
    assign raddr = rptr[SIZE-1:0];

endmodule

// File: rtl/dffs_fifo.sv
// First-word-fall-through FIFO on a flop array; optional bypass via DFFS_FIFO_BYPASS_EN.
// Latency: 1 edge write-to-read (0 in bypass when empty and OREADY=1).
// Backpressure: IREADY = !FULL, a push is refused when full even with a concurrent pop.
module dffs_fifo
    import dffs_fifo_pkg::*;
#(
    parameter int SIZE = 2,
    parameter int WLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            FLUSH,
    input  logic            IVALID,
    output logic            IREADY,
    input  logic [WLEN-1:0] ID,
    output logic            OVALID,
    input  logic            OREADY,
    output logic [WLEN-1:0] OD,
    output logic [SIZE:0]   COUNT,
    output logic            FULL,
    output logic            EMPTY
);

    localparam int DEPTH = 2 ** SIZE;

    logic [WLEN-1:0] mem [DEPTH];
    logic [SIZE-1:0] waddr, raddr;
    logic            push, pop;

    assign IREADY = !FULL;

`ifdef DFFS_FIFO_BYPASS_EN
    logic pass_thru;
    // An empty FIFO with a ready consumer hands the input word straight across.
    assign pass_thru = EMPTY && IVALID && OREADY;
    assign OVALID    = EMPTY ? IVALID : 1'b1;
    assign OD        = EMPTY ? ID : mem[raddr];
    assign push      = IVALID && IREADY && !pass_thru;
    assign pop       = !EMPTY && OREADY;
`else
    assign OVALID = !EMPTY;
    assign OD     = mem[raddr];
    assign push   = IVALID && IREADY;
    assign pop    = OVALID && OREADY;
`endif

    // Storage is deliberately left unreset; flush and reset only move pointers.
    always_ff @(posedge CLK) begin
        if (push && !FLUSH) begin
            mem[waddr] <= ID;
        end
    end

    dffs_fifo_ptr #(.SIZE(SIZE)) u_ptr (
        .CLK   (CLK),
        .RST   (RST),
        .FLUSH (FLUSH),
        .push  (push),
        .pop   (pop),
        .waddr (waddr),
        .raddr (raddr),
        .COUNT (COUNT),
        .FULL  (FULL),
        .EMPTY (EMPTY)
    );

endmodule

// File: tb/tb_dffs_fifo.sv
// Randomised and directed bench for dffs_fifo against a queue model.
// Latency: model updates on each rising edge; outputs sampled 1ns after input changes.
// Backpressure: model refuses pushes when it holds 2**SIZE words.
module tb_dffs_fifo;

    localparam int SIZE  = 2;
    localparam int WLEN  = 8;
    localparam int DEPTH = 4;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            FLUSH = 1'b0;
    logic            IVALID = 1'b0;
    logic            IREADY;
    logic [WLEN-1:0] ID = '0;
    logic            OVALID;
    logic            OREADY = 1'b0;
    logic [WLEN-1:0] OD;
    logic [SIZE:0]   COUNT;
    logic            FULL;
    logic            EMPTY;

    int total  = 0;
    int passed = 0;

    logic [WLEN-1:0] q[$];

    dffs_fifo #(.SIZE(SIZE), .WLEN(WLEN)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .FLUSH  (FLUSH),
        .IVALID (IVALID),
        .IREADY (IREADY),
        .ID     (ID),
        .OVALID (OVALID),
        .OREADY (OREADY),
        .OD     (OD),
        .COUNT  (COUNT),
        .FULL   (FULL),
        .EMPTY  (EMPTY)
    );

    always #5 CLK = ~CLK;

`ifdef DFFS_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endfunction

    // Compare every DUT output against what the queue says must be visible.
    task automatic compare_model();
        bit exp_empty, exp_ovalid;
        exp_empty  = (q.size() == 0);
        exp_ovalid = exp_empty ? (BYP && IVALID) : 1'b1;
        chk("count",  int'(COUNT),  q.size());
        chk("full",   int'(FULL),   int'(q.size() == DEPTH));
        chk("empty",  int'(EMPTY),  int'(exp_empty));
        chk("iready", int'(IREADY), int'(q.size() != DEPTH));
        chk("ovalid", int'(OVALID), int'(exp_ovalid));
        if (exp_ovalid) chk("od", int'(OD), exp_empty ? int'(ID) : int'(q[0]));
    endtask

    // One clock: drive inputs, check, advance the model across the edge, return idle.
    task automatic step(input bit iv, input logic [WLEN-1:0] d, input bit ordy, input bit fl);
        bit full_now, empty_now, do_push, do_pop, pass;
        @(negedge CLK);
        IVALID = iv; ID = d; OREADY = ordy; FLUSH = fl;
        #1;
        compare_model();
        full_now  = (q.size() == DEPTH);
        empty_now = (q.size() == 0);
        pass      = BYP && empty_now && iv && ordy;
        do_push   = iv && !full_now && !pass;
        do_pop    = !empty_now && ordy;
        @(posedge CLK);
        if (fl) q.delete();
        else if (!pass) begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
        #1;
        IVALID = 1'b0; OREADY = 1'b0; FLUSH = 1'b0;
    endtask

    initial begin
        logic [WLEN-1:0] exp_seq [4];
        // Reset then idle
        #12 RST = 1'b1;
        @(negedge CLK); #1;
        chk("rst_count",  int'(COUNT),  0);
        chk("rst_empty",  int'(EMPTY),  1);
        chk("rst_full",   int'(FULL),   0);
        chk("rst_iready", int'(IREADY), 1);
        chk("rst_ovalid", int'(OVALID), 0);

        // Fill to full, then a refused push
        step(1, 8'h11, 0, 0); step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0); step(1, 8'h44, 0, 0);
        chk("fill_full",   int'(FULL),   1);
        chk("fill_count",  int'(COUNT),  4);
        chk("fill_iready", int'(IREADY), 0);
        step(1, 8'h55, 0, 0);
        chk("refuse_od",    int'(OD),    8'h11);
        chk("refuse_count", int'(COUNT), 4);

        // Drain, then refill across pointer wrap and drain again
        exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33; exp_seq[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            chk("drain_od", int'(OD), int'(exp_seq[i]));
            step(0, 8'h00, 1, 0);
        end
        chk("drain_empty", int'(EMPTY), 1);
        for (int i = 0; i < 4; i++) step(1, 8'hA1 + 8'(i), 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_od", int'(OD), 8'hA1 + i);
            step(0, 8'h00, 1, 0);
        end
        chk("wrap_empty", int'(EMPTY), 1);

        // Simultaneous push and pop at COUNT=2
        step(1, 8'h01, 0, 0); step(1, 8'h02, 0, 0);
        step(1, 8'h66, 1, 0);
        chk("pp_count", int'(COUNT), 2);
        chk("pp_head",  int'(OD),    8'h02);
        step(0, 8'h00, 1, 0);
        chk("pp_last",  int'(OD),    8'h66);
        step(0, 8'h00, 1, 0);

        // Flush with a concurrent push at COUNT=3
        step(1, 8'h31, 0, 0); step(1, 8'h32, 0, 0); step(1, 8'h33, 0, 0);
        chk("pre_flush_count", int'(COUNT), 3);
        step(1, 8'h99, 0, 1);
        chk("flush_count", int'(COUNT), 0);
        chk("flush_empty", int'(EMPTY), 1);
        step(0, 8'h00, 0, 0);
        chk("flush_stays_empty", int'(COUNT), 0);

`ifdef DFFS_FIFO_BYPASS_EN
        // Bypass: same-cycle pass-through, then a normal write when consumer stalls
        @(negedge CLK);
        IVALID = 1'b1; ID = 8'h77; OREADY = 1'b1;
        #1;
        chk("byp_ovalid", int'(OVALID), 1);
        chk("byp_od",     int'(OD),     8'h77);
        @(posedge CLK); #1;
        IVALID = 1'b0; OREADY = 1'b0;
        chk("byp_count", int'(COUNT), 0);
        step(1, 8'h77, 0, 0);
        chk("byp_write_count", int'(COUNT), 1);
        step(0, 8'h00, 1, 0);
`endif

        // Random traffic with occasional flush and one asynchronous reset
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                @(negedge CLK);
                #2 RST = 1'b0;
                #1;
                q.delete();
                chk("async_rst_count", int'(COUNT), 0);
                chk("async_rst_empty", int'(EMPTY), 1);
                chk("async_rst_ovalid", int'(OVALID), 0);
                #1 RST = 1'b1;
            end
            step(($urandom_range(0, 99) < 60), WLEN'($urandom),
                 ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 3));
        end

        @(negedge CLK); #1;
        compare_model();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
